// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF) and load/store (D).
// Latency: grant on the edge a request is seen, ready one cycle after mem_ack; minimum 3 cycles per access.
// Backpressure: requesters hold req until their ready pulse; the memory stalls by withholding mem_ack, bounded by a watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, state_nxt;
    logic              owner, last_grant, abort;
    logic [CW-1:0]     wd_cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              grant_vld, grant_d, timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        grant_vld   = 1'b0;
        grant_d     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    grant_vld = 1'b1;
                    // on a tie the requester that did not win last time goes first
                    grant_d   = d_req && (!if_req || last_grant == OWN_IF);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_nxt = RESP;
                end else if (wd_cnt >= CW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_IF;
            last_grant <= OWN_D;
            abort      <= 1'b0;
            wd_cnt     <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (grant_vld) begin
                owner      <= grant_d;
                last_grant <= grant_d;
                wd_cnt     <= '0;
                abort      <= 1'b0;
                lat_addr   <= grant_d ? d_addr : if_addr;
                lat_we     <= grant_d & d_we;
                if (grant_d) lat_wdata <= d_wdata;
            end
            if (state == BUSY) begin
                if (mem_ack) begin
                    abort <= 1'b0;
                    if (!lat_we) begin
                        if (owner == OWN_D) d_rdata_q  <= mem_rdata;
                        else                if_rdata_q <= mem_rdata;
                    end
                end else if (timeout_hit) begin
                    // aborted reads return zero so a stale word is never mistaken for data
                    abort <= 1'b1;
                    if (!lat_we) begin
                        if (owner == OWN_D) d_rdata_q  <= '0;
                        else                if_rdata_q <= '0;
                    end
                end else if (wd_cnt != '1) begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end
    end

    assign mem_req   = (state == BUSY);
    assign mem_we    = lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign if_ready  = (state == RESP) && (owner == OWN_IF);
    assign d_ready   = (state == RESP) && (owner == OWN_D);
    assign err       = (state == RESP) && abort;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single accesses, then hand-written contention and reset sequences.
module tb_mem_port_arbiter;

    localparam int TO = 8;
    localparam logic [31:0] MAGIC = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_ready, d_ready, err;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        auto_ack, force_ack;

    assign mem_ack = auto_ack | force_ack;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  dly;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_busy;
    } vec_t;

    exp_t        sbq[$];
    vec_t        tbl[10];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    int          ack_delay = 0;
    logic        ack_en = 1'b0;
    logic        use_addr_data = 1'b0;
    logic [31:0] rdata_val = 32'h0;
    int          busy_len = 0;
    int          last_busy_len = 0;
    int          rise_cyc = 0;
    logic        prev_req = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [31:0] g_addr, g_wdata;
    logic        g_we;
    logic [31:0] if_rd, d_rd;
    logic        lg;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: event seen where none was required", nm);
    endtask

    task automatic push(input logic is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input logic e);
        exp_t x;
        x.is_d = is_d; x.we = we; x.addr = addr; x.wdata = wdata; x.rdata = rdata; x.err = e;
        sbq.push_back(x);
    endtask

    task automatic wait_ready(output int rc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if_ready || d_ready) begin
                got = 1'b1;
                break;
            end
        end
        rc = cyc;
        if (!got) flag("wait_ready_timeout");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rc, r1, r2, prev;
        bit seen;
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; force_ack = 1'b0; auto_ack = 1'b0;
        mem_rdata = '0;

        fork
            // memory model: ack after ack_delay BUSY cycles when enabled
            forever begin
                @(posedge clk);
                cyc++;
                #1;
                if (mem_req) begin
                    auto_ack = ack_en && (busy_cnt == ack_delay);
                    busy_cnt++;
                end else begin
                    auto_ack = 1'b0;
                    busy_cnt = 0;
                end
                mem_rdata = use_addr_data ? (mem_addr ^ MAGIC) : rdata_val;
            end
            // monitor: grants and readies against the scoreboard
            forever begin
                exp_t e;
                @(negedge clk);
                if (mem_req && !prev_req) begin
                    busy_len = 1;
                    rise_cyc = cyc;
                    g_addr = mem_addr; g_we = mem_we; g_wdata = mem_wdata;
                    if (sbq.size() == 0) flag("unexpected_grant");
                    else begin
                        chk("grant_we", 32'(mem_we), 32'(sbq[0].we));
                        chk("grant_addr", mem_addr, sbq[0].addr);
                        if (sbq[0].we) chk("grant_wdata", mem_wdata, sbq[0].wdata);
                    end
                end else if (mem_req) begin
                    busy_len++;
                    chk("busy_stable_addr", mem_addr, g_addr);
                    chk("busy_stable_we", 32'(mem_we), 32'(g_we));
                    chk("busy_stable_wdata", mem_wdata, g_wdata);
                end
                if (!mem_req && prev_req) last_busy_len = busy_len;
                if (if_ready || d_ready) begin
                    chk("ready_one_hot", 32'(if_ready & d_ready), 32'd0);
                    chk("ready_width", 32'(prev_rdy), 32'd0);
                    if (sbq.size() == 0) flag("unexpected_ready");
                    else begin
                        e = sbq.pop_front();
                        chk("ready_owner_is_d", 32'(d_ready), 32'(e.is_d));
                        chk("ready_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
                        chk("ready_err", 32'(err), 32'(e.err));
                    end
                end else if (err) begin
                    flag("err_without_ready");
                end
                prev_req = mem_req;
                prev_rdy = if_ready | d_ready;
            end
        join_none

        // is_d we addr wdata dly(FF=never) bus_rdata exp_rdata exp_err exp_busy
        tbl[0] = '{1'b0, 1'b0, 32'h100, 32'h0,  8'd3,   32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4};
        tbl[1] = '{1'b1, 1'b1, 32'h200, 32'h55, 8'd0,   32'hFFFFFFFF, 32'h0,        1'b0, 1};
        tbl[2] = '{1'b1, 1'b0, 32'h300, 32'h0,  8'd1,   32'h12345678, 32'h12345678, 1'b0, 2};
        tbl[3] = '{1'b1, 1'b0, 32'h304, 32'h0,  8'hFF,  32'h99999999, 32'h0,        1'b1, TO};
        tbl[4] = '{1'b0, 1'b0, 32'h104, 32'h0,  8'd2,   32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 3};
        tbl[5] = '{1'b0, 1'b0, 32'h108, 32'h0,  8'hFF,  32'h77777777, 32'h0,        1'b1, TO};
        tbl[6] = '{1'b1, 1'b0, 32'h308, 32'h0,  8'd0,   32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1};
        tbl[7] = '{1'b1, 1'b1, 32'h30C, 32'h77, 8'hFF,  32'h0,        32'hA5A5A5A5, 1'b1, TO};
        tbl[8] = '{1'b1, 1'b0, 32'h310, 32'h0,  8'd7,   32'h11112222, 32'h11112222, 1'b0, TO};
        tbl[9] = '{1'b0, 1'b0, 32'h10C, 32'h0,  8'd6,   32'h0BADF00D, 32'h0BADF00D, 1'b0, 7};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);

        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            ack_en = (tbl[k].dly != 8'hFF);
            ack_delay = int'(tbl[k].dly);
            rdata_val = tbl[k].rdata;
            push(tbl[k].is_d, tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].exp_rdata, tbl[k].exp_err);
            if (tbl[k].is_d) begin
                d_req = 1'b1; d_we = tbl[k].we; d_addr = tbl[k].addr; d_wdata = tbl[k].wdata;
            end else begin
                if_req = 1'b1; if_addr = tbl[k].addr;
            end
            wait_ready(rc);
            @(posedge clk); #1;
            if_req = 1'b0; d_req = 1'b0;
            chk($sformatf("busy_cycles[%0d]", k), 32'(last_busy_len), 32'(tbl[k].exp_busy));
        end
        if_rd = 32'h0BADF00D;
        d_rd  = 32'h11112222;

        // spurious ack while idle
        rdata_val = 32'hFFFFFFFF;
        force_ack = 1'b1;
        @(posedge clk); #1;
        force_ack = 1'b0;
        @(negedge clk);
        chk("spur_if_ready", 32'(if_ready), 32'd0);
        chk("spur_d_ready", 32'(d_ready), 32'd0);
        chk("spur_mem_req", 32'(mem_req), 32'd0);
        chk("spur_if_rdata", if_rdata, if_rd);
        chk("spur_d_rdata", d_rdata, d_rd);

        // IF holds req through the IDLE cycle after its ready: exactly one re-grant
        @(posedge clk); #1;
        ack_en = 1'b1; ack_delay = 0; rdata_val = 32'h13579BDF;
        push(1'b0, 1'b0, 32'h800, 32'h0, 32'h13579BDF, 1'b0);
        push(1'b0, 1'b0, 32'h800, 32'h0, 32'h13579BDF, 1'b0);
        if_req = 1'b1; if_addr = 32'h800;
        wait_ready(r1);
        @(negedge clk);
        chk("held_no_grant_in_resp", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0;
        wait_ready(r2);
        chk("held_regrant_cycle", 32'(rise_cyc), 32'(r1 + 2));
        chk("held_round_trip", 32'(r2), 32'(r1 + 3));
        @(posedge clk); #1;

        // reset while BUSY, then a late ack from the aborted access
        ack_en = 1'b0; ack_delay = 255;
        push(1'b0, 1'b0, 32'h900, 32'h0, 32'h0, 1'b0);
        if_req = 1'b1; if_addr = 32'h900;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag("rstbusy_wait_mem_req_timeout");
        @(posedge clk); #1;
        if_req = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; force_ack = 1'b1; rdata_val = 32'hFEEDFACE;
        @(negedge clk);
        chk("rstbusy_mem_req", 32'(mem_req), 32'd0);
        chk("rstbusy_if_ready", 32'(if_ready), 32'd0);
        @(posedge clk); #1;
        force_ack = 1'b0;
        @(negedge clk);
        chk("lateack_mem_req", 32'(mem_req), 32'd0);
        chk("lateack_if_ready", 32'(if_ready), 32'd0);
        chk("lateack_if_rdata", if_rdata, 32'd0);
        chk("lateack_mem_we", 32'(mem_we), 32'd0);
        if (sbq.size() > 0) sbq.delete(0);

        // both request from the cycle after reset: IF, then D store, then IF again
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ack_en = 1'b1; ack_delay = 0; use_addr_data = 1'b1;
        d_rd = 32'h0;
        push(1'b0, 1'b0, 32'h600, 32'h0, 32'h600 ^ MAGIC, 1'b0);
        push(1'b1, 1'b1, 32'h200, 32'h55, d_rd, 1'b0);
        push(1'b0, 1'b0, 32'h604, 32'h0, 32'h604 ^ MAGIC, 1'b0);
        if_req = 1'b1; if_addr = 32'h600;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55;
        wait_ready(rc);
        @(posedge clk); #1;
        if_req = 1'b0;
        wait_ready(rc);
        @(posedge clk); #1;
        d_req = 1'b0; if_req = 1'b1; if_addr = 32'h604;
        wait_ready(rc);
        @(posedge clk); #1;
        if_req = 1'b0;
        lg = 1'b0;

        // both held for 10 accesses: strict alternation, 3 cycles apart
        if_req = 1'b1; if_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_wdata = 32'h0;
        for (int k = 0; k < 10; k++) begin
            logic who;
            who = (k % 2 == 0) ? ~lg : lg;
            push(who, 1'b0, who ? 32'h500 : 32'h400, 32'h0, (who ? 32'h500 : 32'h400) ^ MAGIC, 1'b0);
        end
        prev = 0;
        for (int k = 0; k < 10; k++) begin
            wait_ready(rc);
            if (k > 0) chk($sformatf("ready_spacing[%0d]", k), 32'(rc - prev), 32'd3);
            prev = rc;
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_mem_req", 32'(mem_req), 32'd0);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port of the multicycle CPU between the instruction-fetch requester (IF) and the load/store requester (D). The block accepts one request at a time and drives the memory with a stable request until the memory acknowledges. It then returns a one-cycle completion to the winning requester. Round-robin priority prevents starvation, and a watchdog terminates accesses the memory never acknowledges.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, BUSY cycles without mem_ack before forced abort (≥2)

- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_ready  out  1  one-cycle completion pulse to IF
- if_rdata  out  DATA_W  fetched word, valid with if_ready, held afterwards
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle completion pulse to D
- d_rdata  out  DATA_W  load data, valid with d_ready, held afterwards
- err  out  1  pulses with x_ready when the access timed out
- mem_req  out  1  memory request, high throughout BUSY
- mem_we  out  1  latched write enable
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory

## Operation
- States: IDLE, BUSY, RESP. Registers: owner (IF/D), last_grant (IF/D), wd_cnt, latched we/addr/wdata, if_rdata, d_rdata.
- IDLE:
  - No request pending: stay in IDLE.
  - Exactly one request pending: grant it.
  - Both pending: grant the requester that is not last_grant.
  - On grant: latch the winner's addr; for D also latch we and wdata (IF always latches we = 0); set owner and last_grant; clear wd_cnt; go to BUSY.
- BUSY:
  - mem_req = 1; mem_we, mem_addr and mem_wdata come from the latches and never change during BUSY.
  - mem_ack = 1: on a read, capture mem_rdata into the owner's rdata register (a D store leaves d_rdata unchanged); go to RESP.
  - No ack: wd_cnt increments. When wd_cnt reaches TIMEOUT-1 without an ack, go to RESP with the abort flag set; the owner's rdata is loaded with 0 on a read.
- RESP:
  - Assert the owner's x_ready for exactly one cycle; err = abort flag.
  - No grant is made in RESP, so a requester still holding req while it sees ready is not re-granted.
  - Always go to IDLE.
- mem_ack outside BUSY is ignored: no state change and no data capture.
- Requests arriving during BUSY or RESP wait. A requester must hold req; the arbiter does not queue requests.
- Reset values:
  - state = IDLE, last_grant = D (so IF wins the first tie), owner = IF, wd_cnt = 0.
  - All latches and rdata registers = 0.
  - if_ready = d_ready = err = mem_req = mem_we = 0.
- Reset mid-access: the next edge returns to IDLE with mem_req = 0 and no ready pulse. A late mem_ack from the aborted access is ignored.

## Timing
- mem_req, mem_*, x_ready and err are decoded from registered state and latches; there is no combinational path from inputs to outputs.
- Request seen in IDLE at edge t → mem_req high from cycle t+1.
- mem_ack at cycle a (a ≥ t+1) → x_ready high in cycle a+1 → back in IDLE at a+2. The earliest next grant is sampled at edge a+2.
- Minimum round trip: req at t, ready at t+2, three cycles per access including IDLE.
- Timeout: with no ack, RESP/err occurs TIMEOUT cycles after BUSY entry.
- Back-to-back contention: IF and D alternate strictly. Neither requester waits more than one other access.
- wd_cnt is sized ceil(log2(TIMEOUT))+1 bits and saturates, never wrapping.

## Test plan
- Reset then single IF read: if_req=1, if_addr=0x100; mem_ack 3 cycles after mem_req with mem_rdata=0xDEADBEEF → mem_addr=0x100, mem_we=0, if_ready pulses one cycle later with if_rdata=0xDEADBEEF, err=0, d_ready stays 0.
- Simultaneous first requests: if_req and d_req (store 0x200, wdata 0x55) both asserted from the cycle after reset, immediate acks → IF served first, then D with mem_we=1/mem_wdata=0x55. A third IF request granted after D; d_rdata unchanged by the store.
- Starvation check: both requesters held for 10 accesses, ack every cycle → grants strictly alternate IF,D,IF,…; every ready is exactly one cycle wide and there are 3 cycles between successive readies.
- Timeout: TIMEOUT=8, D load with no ack → mem_req held 8 cycles, d_ready=1 and err=1 together, d_rdata=0. A subsequent normal access has err=0.
- Spurious and late ack: mem_ack pulsed in IDLE → no ready, no rdata change. Reset asserted while BUSY, ack arriving the cycle after reset is released → state IDLE, mem_req=0, no ready pulse.
- Held request after ready: IF keeps if_req=1 for 1 cycle after if_ready (same address) → no second grant during RESP; re-grant only from IDLE, giving a second mem_req beginning 2 cycles after the first if_ready.
